// File: rtl/hog_det_collector.sv
// Collects qualifying SVM detections into a FWFT FIFO and reports per-frame counts.
// Define HOG_DET_NMS_EN to insert the run-based NMS candidate stage ahead of the FIFO.
module hog_det_collector #(
  parameter int FEA_W = 12,
  parameter int SW_W  = 11,
  parameter int N_SW  = 1200,
  parameter int DEPTH = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      i_valid,
  input  logic                      is_person,
  input  logic [FEA_W-1:0]          result,
  input  logic [SW_W-1:0]           sw_id,
  input  logic [FEA_W-1:0]          thr,
  input  logic                      rd_en,
  output logic [SW_W+FEA_W-1:0]     o_data,
  output logic                      o_empty,
  output logic                      o_full,
  output logic [$clog2(DEPTH):0]    o_count,
  output logic                      ovf,
  output logic                      frame_done,
  output logic [SW_W:0]             n_det,
  output logic                      o_nms_state
);

  localparam int AW = $clog2(DEPTH);
  localparam int DW = SW_W + FEA_W;
  localparam logic [SW_W:0]   CNT_MAX = '1;
  localparam logic [SW_W-1:0] LAST_ID = SW_W'(N_SW - 1);

  logic          w_qual;
  logic          w_last;
  logic          w_wr_req;
  logic [DW-1:0] w_wr_data;
  logic          r_flush;

  assign w_qual = i_valid && is_person && ($signed(result) >= $signed(thr));
  assign w_last = i_valid && (sw_id == LAST_ID);

`ifdef HOG_DET_NMS_EN
  typedef enum logic {S_IDLE, S_HOLD} nms_state_t;

  nms_state_t              r_state;
  logic [SW_W-1:0]         r_cand_id;
  logic [SW_W-1:0]         r_last_id;
  logic signed [FEA_W-1:0] r_cand_score;
  logic                    w_consec;

  assign w_consec    = (sw_id == r_last_id + SW_W'(1));
  assign o_nms_state = (r_state == S_HOLD);

  // The held candidate leaves on whatever ends its run: a gap, a non-qualifying valid, or FLUSH.
  always_comb begin
    w_wr_req  = 1'b0;
    w_wr_data = {r_cand_id, r_cand_score};
    if (r_state == S_HOLD) begin
      if (r_flush)
        w_wr_req = 1'b1;
      else if (i_valid && (!w_qual || !w_consec))
        w_wr_req = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= S_IDLE;
      r_cand_id    <= '0;
      r_last_id    <= '0;
      r_cand_score <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_qual) begin
            r_state      <= S_HOLD;
            r_cand_id    <= sw_id;
            r_last_id    <= sw_id;
            r_cand_score <= $signed(result);
          end
        end
        S_HOLD: begin
          if (r_flush) begin
            r_state <= S_IDLE;
          end else if (w_qual) begin
            r_last_id <= sw_id;
            if (!w_consec || ($signed(result) > r_cand_score)) begin
              r_cand_id    <= sw_id;
              r_cand_score <= $signed(result);
            end
          end else if (i_valid) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
`else
  assign w_wr_req    = w_qual;
  assign w_wr_data   = {sw_id, result};
  assign o_nms_state = 1'b0;
`endif

  // Host side: o_data is valid whenever !o_empty; rd_en pops the head, rd_en while empty is ignored.
  logic [DW-1:0] r_mem [DEPTH];
  logic [AW:0]   r_wptr;
  logic [AW:0]   r_rptr;
  logic          w_empty;
  logic          w_full;
  logic          w_push;
  logic          w_pop;

  assign w_empty = (r_wptr == r_rptr);
  assign w_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign w_pop   = rd_en && !w_empty;
  assign w_push  = w_wr_req && (!w_full || rd_en);

  assign o_empty = w_empty;
  assign o_full  = w_full;
  assign o_count = r_wptr - r_rptr;
  assign o_data  = w_empty ? '0 : r_mem[r_rptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr[AW-1:0]] <= w_wr_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + (AW+1)'(1);
      if (w_pop)  r_rptr <= r_rptr + (AW+1)'(1);
    end
  end

  // Counter includes dropped writes and any candidate written during FLUSH itself.
  logic [SW_W:0] r_cnt;
  logic [SW_W:0] w_cnt_next;

  assign w_cnt_next = (w_wr_req && (r_cnt != CNT_MAX)) ? r_cnt + (SW_W+1)'(1) : r_cnt;
  assign frame_done = r_flush;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_flush <= 1'b0;
      r_cnt   <= '0;
      n_det   <= '0;
      ovf     <= 1'b0;
    end else begin
      r_flush <= w_last;
      if (r_flush) begin
        n_det <= w_cnt_next;
        r_cnt <= '0;
        ovf   <= 1'b0;
      end else begin
        r_cnt <= w_cnt_next;
        if (w_wr_req && w_full && !rd_en) ovf <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_hog_det_collector.sv
// Bench for hog_det_collector: directed frames plus random frames scored against a run-level model.
module tb_hog_det_collector;

  localparam int FEA_W = 12;
  localparam int SW_W  = 11;
  localparam int N_SW  = 1200;
  localparam int DEPTH = 16;
  localparam int DW    = SW_W + FEA_W;

  logic              clk = 1'b0;
  logic              rst;
  logic              i_valid;
  logic              is_person;
  logic [FEA_W-1:0]  result;
  logic [SW_W-1:0]   sw_id;
  logic [FEA_W-1:0]  thr;
  logic              rd_en;
  logic [DW-1:0]     o_data;
  logic              o_empty;
  logic              o_full;
  logic [4:0]        o_count;
  logic              ovf;
  logic              frame_done;
  logic [SW_W:0]     n_det;
  logic              o_nms_state;

  hog_det_collector #(.FEA_W(FEA_W), .SW_W(SW_W), .N_SW(N_SW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .i_valid(i_valid), .is_person(is_person), .result(result),
    .sw_id(sw_id), .thr(thr), .rd_en(rd_en), .o_data(o_data), .o_empty(o_empty),
    .o_full(o_full), .o_count(o_count), .ovf(ovf), .frame_done(frame_done),
    .n_det(n_det), .o_nms_state(o_nms_state)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  logic [DW-1:0] exp_q[$];

  logic          s_fd;
  logic          s_ovf;
  logic [4:0]    s_cnt;
  logic [DW-1:0] s_data;
  logic          ovf_seen;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] pack(input int id, input int sc);
    logic [SW_W-1:0]  a;
    logic [FEA_W-1:0] b;
    a = SW_W'(id);
    b = FEA_W'(sc);
    return {a, b};
  endfunction

  // One valid cycle followed by one idle cycle; snapshots outputs one cycle after the valid.
  task automatic send(input int id, input int sc, input bit person, input bit rd);
    i_valid   = 1'b1;
    sw_id     = SW_W'(id);
    result    = FEA_W'(sc);
    is_person = person;
    rd_en     = rd;
    @(posedge clk); #1;
    s_fd   = frame_done;
    s_ovf  = ovf;
    s_cnt  = o_count;
    s_data = o_data;
    ovf_seen |= ovf;
    i_valid   = 1'b0;
    is_person = 1'b0;
    rd_en     = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic end_frame();
    send(N_SW - 1, -1, 1'b0, 1'b0);
  endtask

  task automatic pop();
    rd_en = 1'b1;
    @(posedge clk); #1;
    rd_en = 1'b0;
  endtask

  task automatic drain_check(input string tag);
    while (exp_q.size() > 0) begin
      check_eq({tag, "_count"}, 32'(o_count), 32'(exp_q.size()));
      check_eq({tag, "_data"}, 32'(o_data), 32'(exp_q[0]));
      void'(exp_q.pop_front());
      pop();
    end
    check_eq({tag, "_empty"}, 32'(o_empty), 32'd1);
  endtask

  task automatic rand_frame();
    int ids[$];
    int scs[$];
    bit ps[$];
    bit q[$];
    int run_id[$];
    int run_sc[$];
    logic [DW-1:0] wr[$];
    int t, id, n, pre_flush;
    t  = int'($urandom_range(0, 12)) - 8;
    thr = FEA_W'(t);
    id = int'($urandom_range(0, 40));
    n  = int'($urandom_range(10, 40));
    for (int i = 0; i < n; i++) begin
      ids.push_back(id);
      scs.push_back(int'($urandom_range(0, 25)) - 10);
      ps.push_back($urandom_range(0, 3) != 0);
      id += ($urandom_range(0, 3) == 0) ? 2 : 1;
    end
    ids.push_back(N_SW - 1);
    scs.push_back(int'($urandom_range(0, 25)) - 10);
    ps.push_back($urandom_range(0, 1) != 0);
    for (int i = 0; i < ids.size(); i++) q.push_back(ps[i] && (scs[i] >= t));
`ifdef HOG_DET_NMS_EN
    // Runs: maximal stretches of qualifying windows with consecutive ids; keep first-seen maximum.
    for (int i = 0; i < ids.size(); i++) begin
      if (!q[i]) continue;
      if (i > 0 && q[i-1] && ids[i] == ids[i-1] + 1) begin
        if (scs[i] > run_sc[run_sc.size()-1]) begin
          run_sc[run_sc.size()-1] = scs[i];
          run_id[run_id.size()-1] = ids[i];
        end
      end else begin
        run_id.push_back(ids[i]);
        run_sc.push_back(scs[i]);
      end
    end
    for (int i = 0; i < run_id.size(); i++) wr.push_back(pack(run_id[i], run_sc[i]));
    pre_flush = wr.size() - (q[q.size()-1] ? 1 : 0);
`else
    for (int i = 0; i < ids.size(); i++) if (q[i]) wr.push_back(pack(ids[i], scs[i]));
    pre_flush = wr.size();
`endif
    exp_q.delete();
    for (int i = 0; i < wr.size() && i < DEPTH; i++) exp_q.push_back(wr[i]);
    ovf_seen = 1'b0;
    for (int i = 0; i < ids.size(); i++) send(ids[i], scs[i], ps[i], 1'b0);
    check_eq("rnd_frame_done", 32'(s_fd), 32'd1);
    check_eq("rnd_ovf_seen", 32'(ovf_seen), 32'(pre_flush > DEPTH));
    check_eq("rnd_n_det", 32'(n_det), 32'(wr.size()));
    check_eq("rnd_ovf_clr", 32'(ovf), 32'd0);
    drain_check("rnd");
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b0; i_valid = 1'b0; is_person = 1'b0; result = '0; sw_id = '0;
    thr = '0; rd_en = 1'b0; ovf_seen = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_empty", 32'(o_empty), 32'd1);
    check_eq("rst_full", 32'(o_full), 32'd0);
    check_eq("rst_count", 32'(o_count), 32'd0);
    check_eq("rst_n_det", 32'(n_det), 32'd0);
    check_eq("rst_ovf", 32'(ovf), 32'd0);
    check_eq("rst_fd", 32'(frame_done), 32'd0);
    check_eq("rst_data", 32'(o_data), 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;

`ifndef HOG_DET_NMS_EN
    // Threshold qualification and FWFT ordering.
    thr = '0;
    send(5, 10, 1'b1, 1'b0);
    check_eq("basic_lat_count", 32'(s_cnt), 32'd1);
    check_eq("basic_lat_data", 32'(s_data), 32'(pack(5, 10)));
    send(9, -3, 1'b1, 1'b0);
    send(20, 0, 1'b1, 1'b0);
    check_eq("basic_count", 32'(o_count), 32'd2);
    exp_q = '{pack(5, 10), pack(20, 0)};
    drain_check("basic");
    end_frame();
    check_eq("basic_fd", 32'(s_fd), 32'd1);
    check_eq("basic_n_det", 32'(n_det), 32'd2);

    // Seventeen pushes into sixteen slots with no reads.
    for (int i = 0; i < 17; i++) send(2 * i, 1, 1'b1, 1'b0);
    check_eq("ovf_full", 32'(o_full), 32'd1);
    check_eq("ovf_set", 32'(ovf), 32'd1);
    end_frame();
    check_eq("ovf_fd", 32'(s_fd), 32'd1);
    check_eq("ovf_n_det", 32'(n_det), 32'd17);
    check_eq("ovf_clr", 32'(ovf), 32'd0);
    for (int i = 0; i < 16; i++) exp_q.push_back(pack(2 * i, 1));
    drain_check("ovf");

    // Full FIFO with a pop on the same cycle as the 17th push.
    for (int i = 0; i < 16; i++) send(2 * i, 1, 1'b1, 1'b0);
    send(32, 1, 1'b1, 1'b1);
    check_eq("fullrd_count", 32'(s_cnt), 32'd16);
    check_eq("fullrd_ovf", 32'(s_ovf), 32'd0);
    check_eq("fullrd_head", 32'(s_data), 32'(pack(2, 1)));
    check_eq("fullrd_full", 32'(o_full), 32'd1);
    end_frame();
    check_eq("fullrd_n_det", 32'(n_det), 32'd17);
    for (int i = 1; i <= 16; i++) exp_q.push_back(pack(2 * i, 1));
    drain_check("fullrd");
`else
    // Run 3..5 with a tie at 12 keeps id 4; non-qualifying id 6 ends the run.
    thr = '0;
    send(3, 7, 1'b1, 1'b0);
    send(4, 12, 1'b1, 1'b0);
    send(5, 12, 1'b1, 1'b0);
    check_eq("nms_held_count", 32'(o_count), 32'd0);
    check_eq("nms_hold_state", 32'(o_nms_state), 32'd1);
    send(6, 5, 1'b0, 1'b0);
    check_eq("nms_run_count", 32'(s_cnt), 32'd1);
    check_eq("nms_run_data", 32'(s_data), 32'(pack(4, 12)));
    check_eq("nms_idle_state", 32'(o_nms_state), 32'd0);
    end_frame();
    check_eq("nms_run_n_det", 32'(n_det), 32'd1);

    // Run that is still open at the frame end leaves in FLUSH.
    send(N_SW - 2, 2, 1'b1, 1'b0);
    send(N_SW - 1, 9, 1'b1, 1'b0);
    check_eq("nms_end_fd", 32'(s_fd), 32'd1);
    check_eq("nms_end_count", 32'(o_count), 32'd2);
    check_eq("nms_end_n_det", 32'(n_det), 32'd1);
    exp_q = '{pack(4, 12), pack(N_SW - 1, 9)};
    drain_check("nms_end");
`endif

    for (int f = 0; f < 8; f++) rand_frame();

    // Known non-zero n_det ahead of the asynchronous reset.
    thr = '0;
    send(50, 1, 1'b1, 1'b0);
`ifdef HOG_DET_NMS_EN
    send(52, -1, 1'b0, 1'b0);
`endif
    end_frame();
    check_eq("pre_rst_n_det", 32'(n_det), 32'd1);
    exp_q = '{pack(50, 1)};
    drain_check("pre_rst");

    send(100, 3, 1'b1, 1'b0);
    send(102, 3, 1'b1, 1'b0);
    send(104, 3, 1'b1, 1'b0);
`ifdef HOG_DET_NMS_EN
    send(106, 3, 1'b1, 1'b0);
    check_eq("arst_pre_state", 32'(o_nms_state), 32'd1);
`endif
    check_eq("arst_pre_count", 32'(o_count), 32'd3);
    #2 rst = 1'b0;
    #1;
    check_eq("arst_empty", 32'(o_empty), 32'd1);
    check_eq("arst_count", 32'(o_count), 32'd0);
    check_eq("arst_n_det", 32'(n_det), 32'd0);
    check_eq("arst_data", 32'(o_data), 32'd0);
    check_eq("arst_state", 32'(o_nms_state), 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    end_frame();
    check_eq("post_rst_count", 32'(o_count), 32'd0);
    check_eq("post_rst_empty", 32'(o_empty), 32'd1);
    check_eq("post_rst_n_det", 32'(n_det), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
